ultrasonic_ranger: RTL and testbench

ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

---
 rtl/distance_pkg.sv | 9 +
 rtl/echo_sync.sv | 15 +
 rtl/ultrasonic_ranger.sv | 89 ++++++++
 tb/tb_ultrasonic_ranger.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/distance_pkg.sv
// distance_pkg: ranger state encoding and default timing constants at 50 MHz
package distance_pkg;
  typedef enum logic [1:0] {IDLE, TRIG, WAIT_ECHO, MEASURE} state_t;
  localparam int TRIG_CYCLES_DEF    = 500;
  localparam int CYCLES_PER_CM_DEF  = 2900;
  localparam int TIMEOUT_CYCLES_DEF = 1_900_000;
  localparam int PERIOD_CYCLES_DEF  = 3_000_000;
  localparam logic [15:0] CM_MAX    = 16'hFFFF;
endpackage

// File: rtl/echo_sync.sv
// echo_sync: two-flop synchronizer for the echo pin with rise/fall detection
module echo_sync (
  input  logic clk,
  input  logic reset_l,
  input  logic echo,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [2:0] sr;
  always_ff @(posedge clk) sr <= !reset_l ? 3'b000 : {sr[1:0], echo};
  assign level = sr[1];
  assign rise  = sr[1] & ~sr[2];
  assign fall  = ~sr[1] & sr[2];
endmodule

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: periodic trigger, echo width measurement in cm with timeout
module ultrasonic_ranger
  import distance_pkg::*;
#(
  parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int CYCLES_PER_CM  = CYCLES_PER_CM_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int PERIOD_CYCLES  = PERIOD_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        echo,
  output logic        trigger,
  output logic [15:0] read_data,
  output logic        read_data_valid,
  output logic        timeout,
  output logic        sample_strobe
);
  state_t state;
  logic level, rise, fall;
  logic [31:0] cnt, pcnt, sub;
  logic [15:0] cm;
  echo_sync u_sync (.clk(clk), .reset_l(reset_l), .echo(echo), .level(level), .rise(rise), .fall(fall));
  // the rise cycle is itself the first echo-high cycle, so cnt and sub start at 1
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state           <= TRIG;
      trigger         <= 1'b0;
      read_data       <= 16'd0;
      read_data_valid <= 1'b0;
      timeout         <= 1'b0;
      sample_strobe   <= 1'b0;
      cnt             <= 32'd0;
      pcnt            <= 32'd0;
      sub             <= 32'd0;
      cm              <= 16'd0;
    end else begin
      sample_strobe <= 1'b0;
      pcnt          <= pcnt + 32'd1;
      case (state)
        IDLE: if (pcnt >= PERIOD_CYCLES - 1) begin
          state   <= TRIG;
          trigger <= 1'b1;
          cnt     <= 32'd1;
          pcnt    <= 32'd0;
        end
        TRIG: if (cnt == TRIG_CYCLES) begin
          state   <= WAIT_ECHO;
          trigger <= 1'b0;
          cnt     <= 32'd0;
        end else begin
          if (cnt == 32'd0) pcnt <= 32'd0;
          trigger <= 1'b1;
          cnt     <= cnt + 32'd1;
        end
        WAIT_ECHO: if (rise) begin
          state <= MEASURE;
          cnt   <= 32'd1;
          sub   <= 32'd1;
          cm    <= 16'd0;
        end else if (cnt == TIMEOUT_CYCLES - 1) begin
          state           <= IDLE;
          read_data       <= CM_MAX;
          timeout         <= 1'b1;
          read_data_valid <= 1'b1;
          sample_strobe   <= 1'b1;
        end else cnt <= cnt + 32'd1;
        MEASURE: if (fall) begin
          state           <= IDLE;
          read_data       <= cm;
          timeout         <= 1'b0;
          read_data_valid <= 1'b1;
          sample_strobe   <= 1'b1;
        end else if (level && cnt == TIMEOUT_CYCLES - 1) begin
          state           <= IDLE;
          read_data       <= CM_MAX;
          timeout         <= 1'b1;
          read_data_valid <= 1'b1;
          sample_strobe   <= 1'b1;
        end else begin
          cnt <= cnt + 32'd1;
          sub <= (sub == CYCLES_PER_CM - 1) ? 32'd0 : sub + 32'd1;
          if (sub == CYCLES_PER_CM - 1) cm <= (cm == CM_MAX) ? cm : cm + 16'd1;
        end
        default: state <= TRIG;
      endcase
    end
  end
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: randomized echo widths scored against a cm/timeout reference model
module tb_ultrasonic_ranger;
  localparam int TRIG = 5, CPC = 10, TO = 200, PER = 400;
  logic clk = 1'b0, reset_l = 1'b0, echo = 1'b0;
  logic trigger, read_data_valid, timeout, sample_strobe;
  logic [15:0] read_data;
  int checks = 0, errors = 0;
  logic [15:0] exp_d[$];
  logic exp_t[$];

  always #5 clk = ~clk;

  ultrasonic_ranger #(.TRIG_CYCLES(TRIG), .CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TO), .PERIOD_CYCLES(PER)) dut (
    .clk(clk), .reset_l(reset_l), .echo(echo), .trigger(trigger), .read_data(read_data),
    .read_data_valid(read_data_valid), .timeout(timeout), .sample_strobe(sample_strobe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got none expected event", name);
  endtask

  // reference: an echo of n cycles is floor(n/CPC) cm; none, or n >= TO, is a timeout
  task automatic push_exp(input int n);
    if (n < 0 || n >= TO) begin
      exp_d.push_back(16'hFFFF);
      exp_t.push_back(1'b1);
    end else begin
      exp_d.push_back(16'(n / CPC));
      exp_t.push_back(1'b0);
    end
  endtask

  task automatic wait_trig_fall();
    int k = 0;
    while (!trigger && k < 1000) begin @(negedge clk); k++; end
    if (k >= 1000) bound_fail("trigger_rise");
    k = 0;
    while (trigger && k < 1000) begin @(negedge clk); k++; end
    if (k >= 1000) bound_fail("trigger_fall");
  endtask

  task automatic run(input int d, input int n);
    wait_trig_fall();
    repeat (d) @(negedge clk);
    if (n < 0) begin
      push_exp(-1);
      repeat (TO - d) @(negedge clk);
      chk("no_echo_strobe_at_200", sample_strobe, 1);
    end else begin
      push_exp(n);
      echo = 1'b1;
      repeat (n) @(negedge clk);
      echo = 1'b0;
    end
  endtask

  initial begin : scoreboard
    logic [15:0] d;
    logic t;
    forever begin
      @(negedge clk);
      if (reset_l && sample_strobe) begin
        if (exp_d.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got strobe with read_data=%0h expected none", read_data);
        end else begin
          d = exp_d.pop_front();
          t = exp_t.pop_front();
          chk("read_data", read_data, d);
          chk("timeout", timeout, t);
          chk("read_data_valid", read_data_valid, 1);
        end
      end
    end
  end

  initial begin : trig_mon
    int tcyc = 0, rise_at = -1, prev_rise = -1;
    logic trig_q = 1'b0;
    forever begin
      @(negedge clk);
      tcyc++;
      if (!reset_l) begin
        rise_at = -1;
        prev_rise = -1;
        trig_q = 1'b0;
      end else begin
        if (trigger && !trig_q) begin
          if (prev_rise >= 0) chk("trigger_period", tcyc - prev_rise, PER);
          prev_rise = tcyc;
          rise_at = tcyc;
        end
        if (!trigger && trig_q && rise_at >= 0) chk("trigger_width", tcyc - rise_at, TRIG);
        trig_q = trigger;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, n, cat;
    repeat (3) @(negedge clk);
    chk("reset_trigger", trigger, 0);
    chk("reset_read_data", read_data, 0);
    chk("reset_valid", read_data_valid, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_strobe", sample_strobe, 0);
    reset_l = 1'b1;
    @(negedge clk);
    chk("trigger_first_cycle", trigger, 1);
    chk("read_data_before_result", read_data, 0);
    chk("valid_before_result", read_data_valid, 0);
    run(20, 125);
    run(10, -1);
    run(30, 250);
    run(15, 7);
    run(25, 50);
    run(5, 199);
    run(5, 200);
    run(3, 1);
    repeat (20) begin
      d = int'($urandom_range(1, 60));
      cat = int'($urandom_range(0, 9));
      n = (cat == 0) ? -1 : (cat < 3) ? int'($urandom_range(200, 250)) : int'($urandom_range(1, 199));
      run(d, n);
    end
    wait_trig_fall();
    repeat (10) @(negedge clk);
    echo = 1'b1;
    repeat (30) @(negedge clk);
    reset_l = 1'b0;
    echo = 1'b0;
    @(negedge clk);
    chk("abort_trigger", trigger, 0);
    chk("abort_read_data", read_data, 0);
    chk("abort_valid", read_data_valid, 0);
    chk("abort_timeout", timeout, 0);
    chk("abort_strobe", sample_strobe, 0);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
    chk("trigger_after_abort", trigger, 1);
    run(20, 125);
    repeat (300) @(negedge clk);
    chk("scoreboard_drained", exp_d.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
